// File: rtl/commu_tx.sv
`default_nettype none
// ============================================================================
// Module   : commu_tx
// Brief    : Transmit-side responder for the head/push/tail sequencer
//            handshake. Serializes header, payload (read from the slot
//            buffer) and tail sections onto a valid/ready byte stream and
//            pulses done_* once each section has been fully accepted.
// Revision : 1.0  initial release
// ============================================================================
module commu_tx #(
  parameter int unsigned PAY_LEN = 16,
  parameter logic [7:0]  SYNC0   = 8'hEB,
  parameter logic [7:0]  SYNC1   = 8'h90,
  parameter logic [7:0]  EOF_B   = 8'h0D
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       fire_head,
  input  logic       fire_push,
  input  logic       fire_tail,
  output logic       done_head,
  output logic       done_push,
  output logic       done_tail,
  output logic       buf_rd_en,
  output logic [7:0] buf_rd_addr,
  input  logic [7:0] buf_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  input  logic       tx_rdy,
  output logic [7:0] seq_num
);

  // Length byte sent in the header and index of the final payload byte.
  localparam logic [7:0] c_PAY_LEN  = 8'(PAY_LEN);
  localparam logic [7:0] c_PAY_LAST = 8'(PAY_LEN - 1);
  localparam logic [7:0] c_HEAD_LAST = 8'd3;
  localparam logic [7:0] c_TAIL_LAST = 8'd1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HEAD    = 4'd1,
    S_PUSH_RD = 4'd2,
    S_PUSH_WT = 4'd3,
    S_PUSH_TX = 4'd4,
    S_TAIL    = 4'd5,
    S_DONE_H  = 4'd6,
    S_DONE_P  = 4'd7,
    S_DONE_T  = 4'd8
  } state_t;

  // Registered state and datapath.
  state_t     r_state;
  logic [7:0] r_idx;      // byte index within the current section
  logic [7:0] r_csum;     // running sum of header + payload bytes
  logic [7:0] r_tx_byte;  // payload byte captured from the slot buffer
  logic [7:0] r_seq;      // frame sequence number

  // Next-state values computed by the combinational process.
  state_t     w_state_nxt;
  logic [7:0] w_idx_nxt;
  logic [7:0] w_csum_nxt;
  logic [7:0] w_tx_byte_nxt;
  logic [7:0] w_seq_nxt;

  // State and datapath registers; reset aborts any section in flight.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 8'd0;
      r_csum    <= 8'd0;
      r_tx_byte <= 8'd0;
      r_seq     <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_csum    <= w_csum_nxt;
      r_tx_byte <= w_tx_byte_nxt;
      r_seq     <= w_seq_nxt;
    end
  end

  assign seq_num = r_seq;

  // Next-state logic and state-decoded outputs. tx_vld depends only on the
  // state, so tx_rdy never reaches tx_vld combinationally.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_csum_nxt    = r_csum;
    w_tx_byte_nxt = r_tx_byte;
    w_seq_nxt     = r_seq;
    done_head     = 1'b0;
    done_push     = 1'b0;
    done_tail     = 1'b0;
    buf_rd_en     = 1'b0;
    buf_rd_addr   = 8'd0;
    tx_data       = 8'd0;
    tx_vld        = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Head wins over push, push over tail when pulses coincide.
        if (fire_head) begin
          w_state_nxt = S_HEAD;
          w_idx_nxt   = 8'd0;
          w_csum_nxt  = 8'd0;
        end else if (fire_push) begin
          w_state_nxt = S_PUSH_RD;
          w_idx_nxt   = 8'd0;
        end else if (fire_tail) begin
          w_state_nxt = S_TAIL;
          w_idx_nxt   = 8'd0;
        end
      end

      S_HEAD: begin
        tx_vld = 1'b1;
        case (r_idx)
          8'd0:    tx_data = SYNC0;
          8'd1:    tx_data = SYNC1;
          8'd2:    tx_data = r_seq;
          default: tx_data = c_PAY_LEN;
        endcase
        if (tx_rdy) begin
          w_csum_nxt = r_csum + tx_data;
          if (r_idx == c_HEAD_LAST) begin
            w_state_nxt = S_DONE_H;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end
      end

      S_PUSH_RD: begin
        buf_rd_en   = 1'b1;
        buf_rd_addr = r_idx;
        w_state_nxt = S_PUSH_WT;
      end

      S_PUSH_WT: begin
        // Slot buffer returns data one cycle after the read strobe.
        w_tx_byte_nxt = buf_rd_data;
        w_state_nxt   = S_PUSH_TX;
      end

      S_PUSH_TX: begin
        tx_vld  = 1'b1;
        tx_data = r_tx_byte;
        if (tx_rdy) begin
          w_csum_nxt = r_csum + r_tx_byte;
          if (r_idx == c_PAY_LAST) begin
            w_state_nxt = S_DONE_P;
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
            w_state_nxt = S_PUSH_RD;
          end
        end
      end

      S_TAIL: begin
        tx_vld  = 1'b1;
        tx_data = (r_idx == 8'd0) ? r_csum : EOF_B;
        if (tx_rdy) begin
          if (r_idx == c_TAIL_LAST) begin
            w_state_nxt = S_DONE_T;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end
      end

      S_DONE_H: begin
        done_head   = 1'b1;
        w_state_nxt = S_IDLE;
      end

      S_DONE_P: begin
        done_push   = 1'b1;
        w_state_nxt = S_IDLE;
      end

      S_DONE_T: begin
        // Frame closed: advance the sequence number (wraps naturally).
        done_tail   = 1'b1;
        w_seq_nxt   = r_seq + 8'd1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_commu_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_commu_tx
// Brief    : Self-checking bench for commu_tx. A frame-level model predicts
//            the byte stream of every fired section; a monitor compares
//            each transferred byte, handshake stability and done pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_commu_tx;

  localparam int         PAY_LEN = 16;
  localparam logic [7:0] SYNC0   = 8'hEB;
  localparam logic [7:0] SYNC1   = 8'h90;
  localparam logic [7:0] EOF_B   = 8'h0D;
  localparam int         BUDGET  = 3000;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       fire_head = 1'b0;
  logic       fire_push = 1'b0;
  logic       fire_tail = 1'b0;
  logic       done_head, done_push, done_tail;
  logic       buf_rd_en;
  logic [7:0] buf_rd_addr;
  logic [7:0] buf_rd_data;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rdy = 1'b1;
  logic [7:0] seq_num;

  commu_tx #(
    .PAY_LEN(PAY_LEN), .SYNC0(SYNC0), .SYNC1(SYNC1), .EOF_B(EOF_B)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .fire_head(fire_head), .fire_push(fire_push), .fire_tail(fire_tail),
    .done_head(done_head), .done_push(done_push), .done_tail(done_tail),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .seq_num(seq_num)
  );

  always #5 clk_sys = ~clk_sys;

  // Slot buffer with one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk_sys) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  int n_chk = 0;
  int n_err = 0;
  bit bp_mode = 1'b0;

  // Frame-level model state.
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  logic [7:0] m_seq = 8'd0;
  logic [7:0] m_csum = 8'd0;

  int cnt_h = 0, cnt_p = 0, cnt_t = 0, rd_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  function automatic void chk(input bit ok, input string nm,
                              input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Predict the bytes of a section fired from idle; returns section kind.
  function automatic int model_fire(input bit h, input bit p, input bit t);
    if (h) begin
      exp_q.push_back(SYNC0);
      exp_q.push_back(SYNC1);
      exp_q.push_back(m_seq);
      exp_q.push_back(8'(PAY_LEN));
      m_csum = SYNC0 + SYNC1 + m_seq + 8'(PAY_LEN);
      return 0;
    end else if (p) begin
      for (int i = 0; i < PAY_LEN; i++) begin
        exp_q.push_back(mem[i]);
        m_csum = m_csum + mem[i];
      end
      return 1;
    end else if (t) begin
      exp_q.push_back(m_csum);
      exp_q.push_back(EOF_B);
      m_seq = m_seq + 8'd1;
      return 2;
    end
    return -1;
  endfunction

  // Backpressure driver: always ready, or ready with a 30% duty.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      tx_rdy = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: every cycle, compare transfers to the model and check the
  // handshake invariants.
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk((done_head + done_push + done_tail) <= 1, "done_onehot",
          {done_head, done_push, done_tail}, 0);
      chk(!(tx_vld && (buf_rd_en || done_head || done_push || done_tail)),
          "vld_in_quiet_state", tx_vld, 0);
      if (prev_stall) begin
        chk(tx_vld && (tx_data == prev_data), "stall_stable",
            {tx_vld, tx_data}, {1'b1, prev_data});
      end
      if (tx_vld && tx_rdy) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_byte", tx_data, 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk(tx_data == e, "tx_byte", tx_data, e);
        end
        log_q.push_back(tx_data);
      end
      if (done_head) cnt_h++;
      if (done_push) cnt_p++;
      if (done_tail) cnt_t++;
      if (buf_rd_en) rd_cnt++;
      prev_stall = tx_vld && !tx_rdy;
      prev_data  = tx_data;
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({done_head, done_push, done_tail, buf_rd_en, tx_vld} == 5'd0,
        {tag, "_ctrl_zero"}, {done_head, done_push, done_tail, buf_rd_en, tx_vld}, 0);
    chk(tx_data == 8'd0, {tag, "_tx_data_zero"}, tx_data, 0);
    chk(buf_rd_addr == 8'd0, {tag, "_rd_addr_zero"}, buf_rd_addr, 0);
    chk(seq_num == 8'd0, {tag, "_seq_zero"}, seq_num, 0);
  endtask

  // Fire one (or coincident) request from idle and wait for its done pulse.
  task automatic run_section(input bit h, input bit p, input bit t,
                             output int done_cyc, output int vld_cyc);
    int exp_type, got_type, h0, p0, t0;
    log_q.delete();
    @(posedge clk_sys);
    #1;
    fire_head = h; fire_push = p; fire_tail = t;
    exp_type = model_fire(h, p, t);
    h0 = cnt_h; p0 = cnt_p; t0 = cnt_t;
    @(posedge clk_sys);
    #1;
    fire_head = 1'b0; fire_push = 1'b0; fire_tail = 1'b0;
    done_cyc = 0; vld_cyc = 0; got_type = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk_sys);
      if (tx_vld) vld_cyc++;
      if (done_head || done_push || done_tail) begin
        done_cyc = k;
        got_type = done_head ? 0 : (done_push ? 1 : 2);
        break;
      end
    end
    if (done_cyc == 0) chk(1'b0, "section_timeout", 0, BUDGET);
    else chk(got_type == exp_type, "done_kind", got_type, exp_type);
    repeat (2) @(negedge clk_sys);
    chk(cnt_h - h0 == ((exp_type == 0) ? 1 : 0), "done_head_pulses", cnt_h - h0, exp_type == 0);
    chk(cnt_p - p0 == ((exp_type == 1) ? 1 : 0), "done_push_pulses", cnt_p - p0, exp_type == 1);
    chk(cnt_t - t0 == ((exp_type == 2) ? 1 : 0), "done_tail_pulses", cnt_t - t0, exp_type == 2);
    chk(exp_q.size() == 0, "bytes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    int dc, vc, rd0, p0, n;
    logic [7:0] lit4[4];
    logic [7:0] lit2[2];
    logic [7:0] b;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset state.
    repeat (3) @(negedge clk_sys);
    check_outputs_zero("reset");
    @(posedge clk_sys);
    #1 rst_n = 1'b1;

    // Header with ready held high: cycle-exact timing and literal bytes.
    run_section(1, 0, 0, dc, vc);
    chk(dc == 5, "head_done_cycle", dc, 5);
    chk(vc == 4, "head_vld_cycles", vc, 4);
    lit4 = '{8'hEB, 8'h90, 8'h00, 8'h10};
    chk(log_q.size() == 4, "head_len", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk(log_q[i] == lit4[i], "head_literal", log_q[i], lit4[i]);

    // Payload 00..0F, then tail carrying checksum 03.
    run_section(0, 1, 0, dc, vc);
    chk(dc == 3 * PAY_LEN + 1, "push_done_cycle", dc, 3 * PAY_LEN + 1);
    chk(vc == PAY_LEN, "push_vld_cycles", vc, PAY_LEN);
    for (int i = 0; i < PAY_LEN && i < log_q.size(); i++)
      chk(log_q[i] == 8'(i), "push_literal", log_q[i], i);
    run_section(0, 0, 1, dc, vc);
    chk(dc == 3, "tail_done_cycle", dc, 3);
    lit2 = '{8'h03, 8'h0D};
    for (int i = 0; i < 2 && i < log_q.size(); i++)
      chk(log_q[i] == lit2[i], "tail_literal", log_q[i], lit2[i]);
    chk(seq_num == 8'd1, "seq_after_frame", seq_num, 1);

    // Same frame under random backpressure: seq 1 gives checksum 04.
    bp_mode = 1'b1;
    run_section(1, 0, 0, dc, vc);
    run_section(0, 1, 0, dc, vc);
    run_section(0, 0, 1, dc, vc);
    lit2 = '{8'h04, 8'h0D};
    for (int i = 0; i < 2 && i < log_q.size(); i++)
      chk(log_q[i] == lit2[i], "bp_tail_literal", log_q[i], lit2[i]);
    chk(seq_num == 8'd2, "seq_after_bp_frame", seq_num, 2);
    bp_mode = 1'b0;

    // Coincident head+tail sends the header only; push during a header
    // is ignored.
    rd0 = rd_cnt;
    run_section(1, 0, 1, dc, vc);
    chk(seq_num == 8'd2, "seq_after_head_tail", seq_num, 2);
    p0 = cnt_p;
    fork
      run_section(1, 0, 0, dc, vc);
      begin
        repeat (3) @(posedge clk_sys);
        #1 fire_push = 1'b1;
        @(posedge clk_sys);
        #1 fire_push = 1'b0;
      end
    join
    repeat (10) @(negedge clk_sys);
    chk(rd_cnt == rd0, "busy_no_read", rd_cnt - rd0, 0);
    chk(cnt_p == p0, "busy_no_done_push", cnt_p - p0, 0);

    // Reset in the middle of the payload at byte 7.
    log_q.delete();
    @(posedge clk_sys);
    #1 fire_push = 1'b1;
    void'(model_fire(0, 1, 0));
    @(posedge clk_sys);
    #1 fire_push = 1'b0;
    n = 0;
    while (log_q.size() < 7 && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    chk(log_q.size() == 7, "reach_byte7", log_q.size(), 7);
    p0 = cnt_p;
    @(posedge clk_sys);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (3) @(posedge clk_sys);
    #1;
    exp_q.delete();
    m_csum = 8'd0;
    m_seq = 8'd0;
    rst_n = 1'b1;
    repeat (60) @(negedge clk_sys);
    chk(cnt_p == p0, "midreset_no_done_push", cnt_p - p0, 0);
    run_section(1, 0, 0, dc, vc);
    b = (log_q.size() > 2) ? log_q[2] : 8'hXX;
    chk(b == 8'h00, "post_reset_seq_byte", b, 0);

    // 256 complete frames; the last header carries FF and seq wraps to 0.
    for (int f = 0; f < 256; f++) begin
      run_section(1, 0, 0, dc, vc);
      if (f == 255) begin
        b = (log_q.size() > 2) ? log_q[2] : 8'hXX;
        chk(b == 8'hFF, "wrap_head_seq_ff", b, 8'hFF);
      end
      run_section(0, 1, 0, dc, vc);
      run_section(0, 0, 1, dc, vc);
      chk(seq_num == m_seq, "seq_track", seq_num, m_seq);
    end
    chk(seq_num == 8'd0, "seq_wrapped", seq_num, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commu_tx.md
# commu_tx

Transmit-side responder for the communication sequencer's head/push/tail handshake. It accepts single-cycle `fire_head` / `fire_push` / `fire_tail` pulses and serializes the matching frame section onto a byte stream with a valid/ready handshake. It reads payload bytes from the slot buffer and returns a one-cycle `done_*` pulse when each section has been fully accepted downstream.

## Interface
- `PAY_LEN`, default 16: payload bytes per push, range 1..255; also sent as the header length byte.
- `SYNC0`, default 8'hEB: first header byte.
- `SYNC1`, default 8'h90: second header byte.
- `EOF_B`, default 8'h0D: final tail byte.

Ports:
- `clk_sys`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fire_head`  in  1  one-cycle request: send the header.
- `fire_push`  in  1  one-cycle request: send the payload.
- `fire_tail`  in  1  one-cycle request: send the tail.
- `done_head`  out  1  one-cycle pulse: header fully accepted.
- `done_push`  out  1  one-cycle pulse: payload fully accepted.
- `done_tail`  out  1  one-cycle pulse: tail fully accepted.
- `buf_rd_en`  out  1  slot buffer read strobe.
- `buf_rd_addr`  out  8  slot buffer read address.
- `buf_rd_data`  in  8  slot buffer data, valid exactly 1 cycle after `buf_rd_en`.
- `tx_data`  out  8  byte to transmit.
- `tx_vld`  out  1  `tx_data` is valid.
- `tx_rdy`  in  1  downstream accepts; a byte transfers on any cycle with `tx_vld & tx_rdy`.
- `seq_num`  out  8  current frame sequence number.

## Operation
- States:
  - `S_IDLE`
  - `S_HEAD`: byte index 0..3
  - `S_PUSH_RD`, `S_PUSH_WT`, `S_PUSH_TX`: byte index 0..PAY_LEN-1
  - `S_TAIL`: index 0..1
  - `S_DONE_H`, `S_DONE_P`, `S_DONE_T`
- `S_IDLE` transitions:
  - `fire_head` → `S_HEAD`, idx=0, checksum cleared to 0.
  - else `fire_push` → `S_PUSH_RD`, idx=0.
  - else `fire_tail` → `S_TAIL`, idx=0.
  - Priority is head > push > tail when pulses coincide.
- Header bytes, in order: `SYNC0`, `SYNC1`, `seq_num`, `PAY_LEN`.
- Payload read sequence for each byte:
  - `S_PUSH_RD`: drive `buf_rd_en`=1 with `buf_rd_addr`=idx.
  - `S_PUSH_WT`: capture `buf_rd_data` into the tx register.
  - `S_PUSH_TX`: hold `tx_vld` until accepted.
  - After acceptance: go to `S_PUSH_RD` if idx<PAY_LEN-1, else `S_DONE_P`.
- Tail bytes, in order: checksum, then `EOF_B`.
- Checksum: 8-bit sum, modulo 256, of every header and payload byte transferred since the last `fire_head`. Tail bytes are not included.
- Section completion: when the last byte of a section transfers, go to the matching `S_DONE_x` state. That state asserts `done_x` for one cycle, then returns to `S_IDLE`.
- `seq_num` increments by 1 on `done_tail` and wraps 255→0.
- Any `fire_*` received outside `S_IDLE` is ignored and has no other effect.
- Sections may be fired independently; push and tail never require a preceding head.
- Push-before-head sums the payload onto the stale checksum; this is legal and defined.

## Timing
- Reset values: every output 0, `seq_num`=0, state `S_IDLE`, checksum 0.
- Reset mid-section aborts the section with no `done_*` pulse. `seq_num` is cleared.
- Header with `fire_head` sampled at edge 0 and `tx_rdy`=1 throughout:
  - `tx_vld`=1 during cycles 1..4.
  - `done_head`=1 during cycle 5.
  - Back in `S_IDLE` at cycle 6.
- Payload, `tx_rdy`=1 throughout:
  - 3 cycles per byte.
  - `done_push` in cycle 3·PAY_LEN+1 (cycle 49 for PAY_LEN=16).
- Tail, `tx_rdy`=1 throughout: `tx_vld` in cycles 1..2, `done_tail` in cycle 3.
- Backpressure: while `tx_vld & ~tx_rdy`, `tx_data` and `tx_vld` hold stable and the index does not advance.
- `tx_vld` is never deasserted without a transfer.
- `tx_vld` is 0 in `S_IDLE`, `S_PUSH_RD`, `S_PUSH_WT` and every `S_DONE_x` state.
- Each `done_x` is exactly 1 cycle wide.
- At most one of `done_head` / `done_push` / `done_tail` is high in any cycle.
- All outputs are registered or decoded from state; no combinational path from `tx_rdy` to `tx_vld`.

## Test plan
- Reset, then `fire_head` with `tx_rdy`=1:
  - Bytes EB,90,00,10 in cycles 1..4.
  - `done_head` in cycle 5.
  - Checksum becomes 8'h8B.
- Full frame head/push/tail:
  - Buffer model with 1-cycle read latency holding data[i]=i for i=0..15.
  - `tx_rdy`=1 throughout.
  - Expected payload bytes 00..0F.
  - Tail is (8B+78) mod 256 = 03, then 0D.
  - `seq_num` becomes 1 after `done_tail`.
- Backpressure:
  - `tx_rdy` toggles 0/1 with a random 30% duty.
  - Byte order, values and `tx_data` stability must be identical to the unstalled case.
  - Exactly one `done_*` pulse per section.
- Simultaneous and busy firing:
  - `fire_head` and `fire_tail` in the same cycle → header only.
  - `fire_push` during a header → ignored.
  - Check via `buf_rd_en` never asserting and no `done_push`.
- Wrap: 256 complete frames → `seq_num` returns to 00; frame 256's header carries 8'hFF.
- Reset mid-push: assert `rst_n`=0 at payload byte 7.
  - All outputs 0 and no `done_push`.
  - A subsequent `fire_head` sends 00 in the seq byte.
